// File: rtl/mem_stage_pkg.sv
// Shared widths, load opcodes, response-FSM states and bus layouts for the MEM stage (mirrors marco.h).
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int EX_TO_MEM_LEN = 75;
  localparam int MEM_TO_WB_LEN = 103;
  localparam int MEM_RF_LEN    = 38;
  localparam int DEST_LEN      = 5;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_H    = 3'd2;
  localparam logic [2:0] LD_W    = 3'd3;
  localparam logic [2:0] LD_BU   = 3'd4;
  localparam logic [2:0] LD_HU   = 3'd5;

  // Data-SRAM response tracking for the instruction held in MEM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no response owed
    WAIT = 2'd1,  // request issued by EX, data_ok not yet seen
    HOLD = 2'd2   // response captured in rdata_buf, WB not yet taken it
  } resp_state_t;

  typedef struct packed {
    logic [31:0]         ex_pc;
    logic                gr_we;
    logic [DEST_LEN-1:0] dest;
    logic [31:0]         alu_result;
    logic [2:0]          load_op;
    logic                rfrom_mem;
    logic                mem_req;
  } ex_to_mem_t;

  typedef struct packed {
    logic [31:0]         mem_pc;
    logic                gr_we;
    logic [DEST_LEN-1:0] dest;
    logic [31:0]         mem_result;
    logic [31:0]         alu_result;
    logic                rfrom_mem;
  } mem_to_wb_t;

  typedef struct packed {
    logic [DEST_LEN-1:0] fwd_dest;
    logic                fwd_pending;
    logic [31:0]         fwd_result;
  } mem_rf_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundles the EX->MEM, data-SRAM response, MEM->WB and bypass signals of the MEM stage.
// Latency: n/a (wiring only).
// Backpressure: valid/allowin on both pipeline sides; slave = the MEM stage, master = its surroundings.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                     EX_to_MEM_valid;
  logic                     MEM_allowin;
  logic [EX_TO_MEM_LEN-1:0] EX_to_MEM_BUS;
  logic                     data_sram_data_ok;
  logic [31:0]              data_sram_rdata;
  logic                     MEM_to_WB_valid;
  logic                     WB_allowin;
  logic [MEM_TO_WB_LEN-1:0] MEM_to_WB_BUS;
  logic [MEM_RF_LEN-1:0]    MEM_RF_BUS;

  modport slave (
    input  EX_to_MEM_valid, EX_to_MEM_BUS, data_sram_data_ok, data_sram_rdata, WB_allowin,
    output MEM_allowin, MEM_to_WB_valid, MEM_to_WB_BUS, MEM_RF_BUS
  );

  modport master (
    output EX_to_MEM_valid, EX_to_MEM_BUS, data_sram_data_ok, data_sram_rdata, WB_allowin,
    input  MEM_allowin, MEM_to_WB_valid, MEM_to_WB_BUS, MEM_RF_BUS
  );

endinterface

// File: rtl/mem_stage_load_extend.sv
// Selects the addressed byte/halfword lane of a load word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw_data,
  input  logic [1:0]  a,
  input  logic [2:0]  load_op,
  output logic [31:0] extended
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection: byte by full offset, halfword by offset bit 1 (misalignment is not trapped here).
  always_comb begin
    byte_sel = raw_data[{a, 3'b000} +: 8];
    half_sel = a[1] ? raw_data[31:16] : raw_data[15:0];
  end

  // Extension by load opcode; non-load opcodes yield zero.
  always_comb begin
    extended = '0;
    case (load_op)
      LD_B:    extended = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   extended = {24'b0, byte_sel};
      LD_H:    extended = {{16{half_sel[15]}}, half_sel};
      LD_HU:   extended = {16'b0, half_sel};
      LD_W:    extended = raw_data;
      LD_NONE: extended = '0;
      default: extended = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response of the held instruction, extends loads, hands off to WB; optional bypass bus under MEM_FWD_EN.
// Latency: 1 cycle register from EX; 0 extra cycles if data_ok arrives in the entry cycle, otherwise stalls until it does.
// Backpressure: MEM_allowin drops while the response is outstanding or WB refuses; an early response is parked in rdata_buf.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mem_stage_if.slave   bus
);

  ex_to_mem_t  in_bus;
  ex_to_mem_t  bus_r;
  mem_to_wb_t  wb_bus;
  mem_rf_t     rf_bus;
  logic        mem_valid;
  logic        ready_go;
  logic        allowin;
  logic        to_wb_valid;
  logic        enter;
  logic        leave;
  resp_state_t state;
  resp_state_t state_nxt;
  logic [31:0] rdata_buf;
  logic [31:0] raw_data;
  logic [31:0] extended;
  logic [31:0] mem_result;

  assign in_bus = bus.EX_to_MEM_BUS;

  // Handshake: ready when no response is owed, the response is arriving now, or it is already buffered.
  always_comb begin
    ready_go    = !bus_r.mem_req || (state == WAIT && bus.data_sram_data_ok) || (state == HOLD);
    allowin     = !mem_valid || (ready_go && bus.WB_allowin);
    to_wb_valid = mem_valid && ready_go;
    enter       = bus.EX_to_MEM_valid && allowin;
    leave       = to_wb_valid && bus.WB_allowin;
  end

  // Stage occupancy: refreshed from EX whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
    end else if (allowin) begin
      mem_valid <= bus.EX_to_MEM_valid;
    end
  end

  // Instruction register: loads only on an actual transfer from EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_r <= '0;
    end else if (enter) begin
      bus_r <= in_bus;
    end
  end

  // Response FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Response FSM next state; data_ok outside WAIT is a protocol error and is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enter && in_bus.mem_req) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.data_sram_data_ok) begin
          if (leave) state_nxt = (enter && in_bus.mem_req) ? WAIT : IDLE;
          else       state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (leave) state_nxt = (enter && in_bus.mem_req) ? WAIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Park the response when it arrives but WB cannot take the instruction this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf <= '0;
    end else if (state == WAIT && bus.data_sram_data_ok && !leave) begin
      rdata_buf <= bus.data_sram_rdata;
    end
  end

  assign raw_data = (state == HOLD) ? rdata_buf : bus.data_sram_rdata;

  load_extend u_load_extend (
    .raw_data (raw_data),
    .a        (bus_r.alu_result[1:0]),
    .load_op  (bus_r.load_op),
    .extended (extended)
  );

  assign mem_result = bus_r.rfrom_mem ? extended : 32'b0;

  // WB bus: register contents plus the extended load result; WB selects between the two results.
  always_comb begin
    wb_bus.mem_pc     = bus_r.ex_pc;
    wb_bus.gr_we      = bus_r.gr_we;
    wb_bus.dest       = bus_r.dest;
    wb_bus.mem_result = mem_result;
    wb_bus.alu_result = bus_r.alu_result;
    wb_bus.rfrom_mem  = bus_r.rfrom_mem;
  end

`ifdef MEM_FWD_EN
  // Bypass bus: dest only while a register-writing instruction is held; pending flags a load still in flight.
  always_comb begin
    rf_bus.fwd_dest    = bus_r.dest & {DEST_LEN{bus_r.gr_we && mem_valid}};
    rf_bus.fwd_pending = mem_valid && bus_r.rfrom_mem && !ready_go;
    rf_bus.fwd_result  = bus_r.rfrom_mem ? mem_result : bus_r.alu_result;
  end
`else
  // Bypass disabled: the bus stays in place but carries nothing.
  always_comb begin
    rf_bus = '0;
  end
`endif

  assign bus.MEM_allowin     = allowin;
  assign bus.MEM_to_WB_valid = to_wb_valid;
  assign bus.MEM_to_WB_BUS   = wb_bus;
  assign bus.MEM_RF_BUS      = rf_bus;

endmodule
